// File: rtl/axi_ddr_pkg.sv
// Shared types and constants for the DDR AXI write-burst scheduler.
package axi_ddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    UPD  = 2'd3
  } sched_state_t;

  // 32-bit words covered by one DATA_W beat, as a shift amount.
  function automatic int unsigned beat_shift(input int unsigned data_w);
    return $clog2(data_w / 32);
  endfunction

  // Address increment (in words) of one full burst.
  function automatic int unsigned inc_words(input int unsigned burst_len,
                                            input int unsigned data_w);
    return burst_len * (data_w / 32);
  endfunction

endpackage

// File: rtl/axi_wr_burst_sched_rr_arbiter.sv
// Round-robin arbiter: first requester after the last accepted grant wins.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_last;
  int unsigned   w_c;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_c     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_c = 32'(r_last) + k;
      if (w_c >= N) w_c = w_c - N;
      if (!o_valid && i_req[IW'(w_c)]) begin
        o_valid = 1'b1;
        o_idx   = IW'(w_c);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_last <= IW'(N - 1);
    else if (i_accept) r_last <= o_idx;
  end

endmodule

// File: rtl/axi_wr_burst_sched.sv
// Multi-channel AXI write-burst scheduler with per-channel rotating buffers.
// Optional WR_FLUSH_TIMEOUT_EN: partial-burst flush after TIMEOUT idle cycles.
module axi_wr_burst_sched
  import axi_ddr_pkg::*;
#(
  parameter  int unsigned CH_NUM    = 4,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned DATA_W    = 256,
  parameter  int unsigned LVL_W     = 8,
  parameter  int unsigned BURST_LEN = 16,
  parameter  int unsigned BUF_NUM   = 2,
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     ui_clk,
  input  logic                     ui_rst_n,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic [CH_NUM-1:0]        ch_rst,
  input  logic [CH_NUM*ADDR_W-1:0] ch_b_addr,
  input  logic [CH_NUM*ADDR_W-1:0] ch_region,
  input  logic [CH_NUM*LVL_W-1:0]  ch_fifo_lvl,
  input  logic                     wr_ready,
  input  logic                     wr_burst_finish,
  output logic                     wr_burst_req,
  output logic [ADDR_W-1:0]        wr_burst_addr,
  output logic [9:0]               wr_burst_len,
  output logic [CHW-1:0]           wr_burst_ch,
  output logic [CH_NUM*2-1:0]      ch_wr_buf,
  output logic [CH_NUM-1:0]        ch_frame_done
);

  localparam int unsigned INC   = inc_words(BURST_LEN, DATA_W);
  localparam int unsigned SHIFT = beat_shift(DATA_W);
  localparam int unsigned AW1   = ADDR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] ofs;
    logic [1:0]        buf_idx;
  } ch_ptr_t;

  sched_state_t      r_state, w_next;
  ch_ptr_t           r_ptr [CH_NUM];
  logic [CHW-1:0]    r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic [9:0]        r_len;
  logic [ADDR_W-1:0] r_words;
  logic              r_rst_hit;
  logic [CH_NUM-1:0] r_frame_done;

  logic [ADDR_W-1:0] w_base   [CH_NUM];
  logic [ADDR_W-1:0] w_region [CH_NUM];
  logic [LVL_W-1:0]  w_lvl    [CH_NUM];
  logic [CH_NUM-1:0] w_full;
  logic [CH_NUM-1:0] w_arb_req;
  logic [CHW-1:0]    w_sel;
  logic              w_arb_valid;
  logic              w_accept;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [9:0]        w_grant_len;
  logic [ADDR_W-1:0] w_grant_words;
  logic [ADDR_W-1:0] w_ofs_sum;
  logic              w_wrap;
  logic [1:0]        w_buf_next;

  always_comb begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      w_base[i]   = ch_b_addr[i*ADDR_W +: ADDR_W];
      w_region[i] = ch_region[i*ADDR_W +: ADDR_W];
      w_lvl[i]    = ch_fifo_lvl[i*LVL_W +: LVL_W];
      w_full[i]   = ch_en[i] & ~ch_rst[i] & (32'(w_lvl[i]) >= BURST_LEN);
    end
  end

`ifdef WR_FLUSH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;
  logic [TW-1:0]     r_idle [CH_NUM];
  logic [CH_NUM-1:0] w_flush;
  logic              w_is_flush;

  always_comb begin
    for (int unsigned i = 0; i < CH_NUM; i++)
      w_flush[i] = ch_en[i] & ~ch_rst[i] & (w_lvl[i] != '0) &
                   (32'(w_lvl[i]) < BURST_LEN) & (32'(r_idle[i]) >= TIMEOUT);
    // Full bursts always win; partial flushes only compete when none is ready.
    w_is_flush    = ~|w_full;
    w_arb_req     = w_is_flush ? w_flush : w_full;
    w_grant_len   = w_is_flush ? 10'(32'(w_lvl[w_sel]) - 1) : 10'(BURST_LEN - 1);
    w_grant_words = w_is_flush ? (ADDR_W'(w_lvl[w_sel]) << SHIFT)
                               : (ADDR_W'(BURST_LEN) << SHIFT);
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) r_idle[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (ch_rst[i] || (w_lvl[i] == '0) || (w_accept && (w_sel == CHW'(i))))
          r_idle[i] <= '0;
        else if ((32'(w_lvl[i]) < BURST_LEN) && (32'(r_idle[i]) < TIMEOUT))
          r_idle[i] <= r_idle[i] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_arb_req     = w_full;
    w_grant_len   = 10'(BURST_LEN - 1);
    w_grant_words = ADDR_W'(BURST_LEN) << SHIFT;
  end
`endif

  rr_arbiter #(.N(CH_NUM)) u_arb (
    .i_clk    (ui_clk),
    .i_rst_n  (ui_rst_n),
    .i_req    (w_arb_req),
    .i_accept (w_accept),
    .o_idx    (w_sel),
    .o_valid  (w_arb_valid)
  );

  always_comb begin
    w_grant_addr = w_base[w_sel] + ADDR_W'(r_ptr[w_sel].buf_idx) * w_region[w_sel]
                 + r_ptr[w_sel].ofs;
    w_ofs_sum    = r_ptr[r_ch].ofs + r_words;
    w_wrap       = ({1'b0, w_ofs_sum} + AW1'(INC)) > {1'b0, w_region[r_ch]};
    w_buf_next   = (r_ptr[r_ch].buf_idx == 2'(BUF_NUM - 1)) ? 2'd0
                                                            : r_ptr[r_ch].buf_idx + 2'd1;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (wr_ready && w_arb_valid) begin
        w_next   = REQ;
        w_accept = 1'b1;
      end
      REQ:  w_next = BUSY;
      BUSY: if (wr_burst_finish) w_next = UPD;
      UPD:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_addr    <= '0;
      r_len     <= 10'(BURST_LEN - 1);
      r_words   <= '0;
      r_rst_hit <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ch      <= w_sel;
        r_addr    <= w_grant_addr;
        r_len     <= w_grant_len;
        r_words   <= w_grant_words;
        r_rst_hit <= 1'b0;
      end else if ((r_state != IDLE) && ch_rst[r_ch]) begin
        // A restart seen at any point of the burst suppresses its pointer update.
        r_rst_hit <= 1'b1;
      end
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) r_ptr[i] <= '0;
      r_frame_done <= '0;
    end else begin
      r_frame_done <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (ch_rst[i]) begin
          r_ptr[i] <= '0;
        end else if ((r_state == UPD) && (r_ch == CHW'(i)) && !r_rst_hit) begin
          if (w_wrap) begin
            r_ptr[i].ofs     <= '0;
            r_ptr[i].buf_idx <= w_buf_next;
            r_frame_done[i]  <= 1'b1;
          end else begin
            r_ptr[i].ofs <= w_ofs_sum;
          end
        end
      end
    end
  end

  always_comb begin
    ch_wr_buf = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) ch_wr_buf[2*i +: 2] = r_ptr[i].buf_idx;
  end

  assign wr_burst_req  = (r_state == REQ);
  assign wr_burst_addr = r_addr;
  assign wr_burst_len  = r_len;
  assign wr_burst_ch   = r_ch;
  assign ch_frame_done = r_frame_done;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Self-checking bench for axi_wr_burst_sched (2 channels, 2 buffers, region 256 words).
module tb_axi_wr_burst_sched;

  localparam int CH_NUM    = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 256;
  localparam int LVL_W     = 8;
  localparam int BURST_LEN = 16;
  localparam int BUF_NUM   = 2;
  localparam int TIMEOUT   = 8;
  localparam int WPB       = DATA_W / 32;
  localparam int INC       = BURST_LEN * WPB;
  localparam logic [31:0] REGION = 32'd256;
  localparam logic [31:0] B0     = 32'h0000_1000;
  localparam logic [31:0] B1     = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_en, ch_rst;
  logic [63:0] ch_b_addr, ch_region;
  logic [15:0] lvl;
  logic        wr_ready, finish;
  logic        req;
  logic [31:0] addr;
  logic [9:0]  len;
  logic [0:0]  bch;
  logic [3:0]  wr_buf;
  logic [1:0]  fd;

  int errors = 0;
  int checks = 0;

  int unsigned m_ofs [CH_NUM];
  int unsigned m_buf [CH_NUM];
  int          m_last;
  logic [31:0] base  [CH_NUM];

  axi_wr_burst_sched #(
    .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W),
    .BURST_LEN(BURST_LEN), .BUF_NUM(BUF_NUM), .TIMEOUT(TIMEOUT)
  ) dut (
    .ui_clk(clk), .ui_rst_n(rst_n), .ch_en(ch_en), .ch_rst(ch_rst),
    .ch_b_addr(ch_b_addr), .ch_region(ch_region), .ch_fifo_lvl(lvl),
    .wr_ready(wr_ready), .wr_burst_finish(finish), .wr_burst_req(req),
    .wr_burst_addr(addr), .wr_burst_len(len), .wr_burst_ch(bch),
    .ch_wr_buf(wr_buf), .ch_frame_done(fd)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input int c);
    return base[c] + 32'(m_buf[c]) * REGION + 32'(m_ofs[c]);
  endfunction

  function automatic int pick();
    for (int k = 1; k <= CH_NUM; k++) begin
      int c = (m_last + k) % CH_NUM;
      if (ch_en[c] && !ch_rst[c] && lvl[c*8 +: 8] >= BURST_LEN) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_wbuf();
    return {2'(m_buf[1]), 2'(m_buf[0])};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      m_ofs[c] = 0;
      m_buf[c] = 0;
    end
    m_last = CH_NUM - 1;
  endfunction

  // One burst: wait for the request, check it, hold BUSY, finish, then check the update.
  task automatic do_burst(input string nm, input int ec, input logic [31:0] ea,
                          input int elen, input logic [1:0] rstm, input bit drop_en,
                          input int beats, output int waited);
    bit         ok = 0;
    int         busy;
    logic [1:0] exp_fd = 2'b00;
    waited = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (req) begin
        ok = 1;
        waited = k;
        break;
      end
    end
    check({nm, " req seen"}, 64'(ok), 64'd1);
    if (!ok) return;
    check({nm, " ch"}, 64'(bch), 64'(ec));
    check({nm, " addr"}, 64'(addr), 64'(ea));
    check({nm, " len"}, 64'(len), 64'(elen));
    m_last = ec;
    busy = $urandom_range(1, 4);
    for (int k = 0; k < busy; k++) begin
      @(negedge clk);
      check({nm, " no req in busy"}, 64'(req), 64'd0);
      if (k == 0) begin
        ch_rst = rstm;
        if (drop_en) ch_en[ec] = 1'b0;
      end else begin
        ch_rst = 2'b00;
      end
    end
    @(negedge clk);
    ch_rst = 2'b00;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    for (int c = 0; c < CH_NUM; c++)
      if (rstm[c]) begin
        m_ofs[c] = 0;
        m_buf[c] = 0;
      end
    if (!rstm[ec]) begin
      m_ofs[ec] += beats * WPB;
      if (m_ofs[ec] + INC > REGION) begin
        m_ofs[ec] = 0;
        m_buf[ec] = (m_buf[ec] + 1) % BUF_NUM;
        exp_fd[ec] = 1'b1;
      end
    end
    check({nm, " frame_done"}, 64'(fd), 64'(exp_fd));
    check({nm, " wr_buf"}, 64'(wr_buf), 64'(model_wbuf()));
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [7:0]  l0, l1;
    int          ch;
    logic [31:0] addr;
    logic [3:0]  wbuf;
  } vec_t;

  vec_t tbl [8];
  int   lv_opts [4] = '{0, 16, 40, 255};

  initial begin
    int w;
    int p;
    bit seen;
    tbl[0] = '{2'b11, 8'd16, 8'd0,  0, 32'h1000, 4'b0000};
    tbl[1] = '{2'b11, 8'd16, 8'd16, 1, 32'h8000, 4'b0000};
    tbl[2] = '{2'b11, 8'd16, 8'd16, 0, 32'h1080, 4'b0001};
    tbl[3] = '{2'b11, 8'd16, 8'd16, 1, 32'h8080, 4'b0101};
    tbl[4] = '{2'b11, 8'd16, 8'd0,  0, 32'h1100, 4'b0101};
    tbl[5] = '{2'b11, 8'd16, 8'd0,  0, 32'h1180, 4'b0100};
    tbl[6] = '{2'b11, 8'd16, 8'd0,  0, 32'h1000, 4'b0100};
    tbl[7] = '{2'b10, 8'd16, 8'd16, 1, 32'h8100, 4'b0100};

    base[0] = B0;
    base[1] = B1;
    model_reset();
    rst_n = 1'b0;
    ch_en = 2'b11;
    ch_rst = 2'b00;
    ch_b_addr = {B1, B0};
    ch_region = {REGION, REGION};
    lvl = '0;
    wr_ready = 1'b1;
    finish = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req", 64'(req), 64'd0);
    check("reset addr", 64'(addr), 64'd0);
    check("reset len", 64'(len), 64'(BURST_LEN - 1));
    check("reset ch", 64'(bch), 64'd0);
    check("reset wr_buf", 64'(wr_buf), 64'd0);
    check("reset frame_done", 64'(fd), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ch_en = tbl[i].en;
      lvl = {tbl[i].l1, tbl[i].l0};
      do_burst($sformatf("vec%0d", i), tbl[i].ch, tbl[i].addr, BURST_LEN - 1,
               2'b00, 1'b0, BURST_LEN, w);
      check($sformatf("vec%0d table wr_buf", i), 64'(wr_buf), 64'(tbl[i].wbuf));
    end

    ch_en = 2'b11;
    lvl = {8'd0, 8'd16};
    do_burst("rst mid busy", 0, 32'h1080, BURST_LEN - 1, 2'b01, 1'b0, BURST_LEN, w);
    do_burst("after rst", 0, 32'h1000, BURST_LEN - 1, 2'b00, 1'b0, BURST_LEN, w);

    for (int it = 0; it < 40; it++) begin
      ch_rst = 2'b00;
      ch_en = 2'($urandom_range(0, 3));
      lvl = {8'(lv_opts[$urandom_range(0, 3)]), 8'(lv_opts[$urandom_range(0, 3)])};
      p = pick();
      if (p < 0) begin
        seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (req) seen = 1;
        end
        check("idle no req", 64'(seen), 64'd0);
      end else begin
        do_burst("rand", p, model_addr(p), BURST_LEN - 1,
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(0, 3) == 0, BURST_LEN, w);
      end
    end

    ch_rst = 2'b00;
    ch_en = 2'b11;
    lvl = {8'd16, 8'd16};
    p = pick();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req) begin
        seen = 1;
        break;
      end
    end
    check("pre-reset req seen", 64'(seen), 64'd1);
    check("pre-reset ch", 64'(bch), 64'(p));
    check("pre-reset addr", 64'(addr), 64'(model_addr(p)));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset req", 64'(req), 64'd0);
    check("async reset addr", 64'(addr), 64'd0);
    check("async reset len", 64'(len), 64'(BURST_LEN - 1));
    check("async reset ch", 64'(bch), 64'd0);
    check("async reset wr_buf", 64'(wr_buf), 64'd0);
    check("async reset frame_done", 64'(fd), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_burst("post reset", 0, B0, BURST_LEN - 1, 2'b00, 1'b0, BURST_LEN, w);

`ifdef WR_FLUSH_TIMEOUT_EN
    lvl = {8'd0, 8'd0};
    ch_rst = 2'b01;
    @(negedge clk);
    ch_rst = 2'b00;
    m_ofs[0] = 0;
    m_buf[0] = 0;
    lvl = {8'd0, 8'd5};
    do_burst("flush", 0, B0, 4, 2'b00, 1'b0, 5, w);
    check("flush latency in window", 64'(w >= 7 && w <= 12), 64'd1);
    lvl = {8'd0, 8'd16};
    do_burst("after flush", 0, B0 + 32'd40, BURST_LEN - 1, 2'b00, 1'b0, BURST_LEN, w);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
